// File: rtl/tcp_buf_pkg.sv
// tcp_buf_pkg: shared defaults and pointer arithmetic helpers for the TCP send ring buffer.
package tcp_buf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 14;
  // Operands are zero-extended by callers; truncating the result keeps modulo-2**CNT_W semantics.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction
  function automatic logic [31:0] min_cnt(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port; array is never reset.
module sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/tcp_tx_ring_buffer.sv
// tcp_tx_ring_buffer: circular TCP send buffer with write, read and release pointers plus rewind.
module tcp_tx_ring_buffer
  import tcp_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int CNT_W = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_ready,
  output logic              wr_drop,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  input  logic              rd_rewind,
  input  logic              release_en,
  input  logic [CNT_W-1:0]  release_count,
  output logic              release_err,
  output logic [CNT_W-1:0]  used_count,
  output logic [CNT_W-1:0]  unread_count,
  output logic              full,
  output logic              empty
);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2**ADDR_W);
  logic [CNT_W-1:0] wr_q, wr_d, rd_q, rd_d, rel_q, rel_d, avail, rel_amt;
  logic wr_acc, rd_acc, rel_err_d;
  logic rd_valid_q, wr_drop_q, release_err_q;
  assign used_count   = CNT_W'(ptr_diff(32'(wr_q), 32'(rel_q)));
  assign unread_count = CNT_W'(ptr_diff(32'(wr_q), 32'(rd_q)));
  assign avail        = CNT_W'(ptr_diff(32'(rd_q), 32'(rel_q)));
  assign full         = used_count == DEPTH;
  assign empty        = used_count == '0;
  assign wr_ready     = !full;
  // Rewind lands on the release pointer after this cycle's release, so it uses rel_d.
  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && unread_count != '0 && !rd_rewind;
    rel_amt   = release_en ? CNT_W'(min_cnt(32'(release_count), 32'(avail))) : '0;
    rel_err_d = release_en && release_count > avail;
    rel_d     = rel_q + rel_amt;
    wr_d      = wr_q + CNT_W'(wr_acc);
    rd_d      = rd_rewind ? rel_d : rd_q + CNT_W'(rd_acc);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q          <= '0;
      rd_q          <= '0;
      rel_q         <= '0;
      rd_valid_q    <= 1'b0;
      wr_drop_q     <= 1'b0;
      release_err_q <= 1'b0;
    end else begin
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      rel_q         <= rel_d;
      rd_valid_q    <= rd_acc;
      wr_drop_q     <= wr_en && full;
      release_err_q <= rel_err_d;
    end
  end
  sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .rst     (reset),
    .we_i    (wr_acc && !reset),
    .waddr_i (wr_q[ADDR_W-1:0]),
    .wdata_i (data_in),
    .re_i    (rd_acc && !reset),
    .raddr_i (rd_q[ADDR_W-1:0]),
    .rdata_o (data_out)
  );
  assign rd_valid    = rd_valid_q;
  assign wr_drop     = wr_drop_q;
  assign release_err = release_err_q;
endmodule

// File: doc/tcp_tx_ring_buffer.md
Name: tcp_tx_ring_buffer

Overview:
- Parametrised successor to the flat buffer memory: a circular send buffer for the TCP/UDP datapath, with pointer management handled internally instead of by the caller.
- Three pointers:
  - write: the packetiser appends payload words here.
  - read: the transmitter streams words from here.
  - release: acknowledged words are freed here.
- Supports retransmission: the read pointer rewinds to the oldest unacknowledged word.
- Sits between the payload source and the TCP segment builder.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 14, log2 of depth; DEPTH = 2**ADDR_W words.
- CNT_W, ADDR_W+1, width of pointers and counters; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  append data_in at the write pointer.
- data_in  in  DATA_W  write data.
- wr_ready  out  1  high when not full.
- wr_drop  out  1  one-cycle pulse: write attempted while full.
- rd_en  in  1  read the next unread word.
- data_out  out  DATA_W  read data.
- rd_valid  out  1  data_out carries a word accepted the previous cycle.
- rd_rewind  in  1  set the read pointer equal to the release pointer (retransmit).
- release_en  in  1  free release_count words.
- release_count  in  CNT_W  number of words acknowledged.
- release_err  out  1  one-cycle pulse: release was clamped.
- used_count  out  CNT_W  wr_ptr - rel_ptr.
- unread_count  out  CNT_W  wr_ptr - rd_ptr.
- full  out  1  used_count == DEPTH.
- empty  out  1  used_count == 0.

Behaviour:
- Pointers are CNT_W bits (the MSB is the wrap bit); the RAM is addressed by the low ADDR_W bits. All pointer subtraction is modulo 2**CNT_W.
- Reset (synchronous, checked on the clk edge):
  - wr_ptr = rd_ptr = rel_ptr = 0.
  - data_out = 0; rd_valid, wr_drop, release_err = 0.
  - Consequently full = 0, empty = 1, wr_ready = 1, both counts = 0.
  - RAM contents are not cleared. Reset overrides every same-cycle request.
- Write:
  - Accepted when wr_en && !full: RAM[wr_ptr] <= data_in, wr_ptr += 1.
  - When wr_en && full: no change to RAM or pointers; wr_drop = 1 on the next cycle.
- Read:
  - Accepted when rd_en && unread_count != 0 && !rd_rewind: rd_ptr += 1.
  - data_out = RAM[old rd_ptr] and rd_valid = 1 on the next cycle (latency 1).
  - When not accepted: rd_valid = 0 next cycle and data_out holds its last value.
  - No write-to-read bypass: a read issued with unread_count == 0 is rejected even if a write arrives in the same cycle.
- Release:
  - avail = rd_ptr - rel_ptr, i.e. only words already read may be freed.
  - rel_ptr += min(release_count, avail).
  - If release_count > avail, release_err = 1 on the next cycle.
  - release_count == 0 is a legal no-op.
- Rewind: rd_ptr <= rel_ptr after this cycle's release has been applied, i.e. the new rel_ptr. Rewind wins over rd_en in the same cycle.
- Simultaneous events:
  - Write, release and rewind in one cycle are all applied.
  - full, empty and wr_ready are computed from registered pointers only, so a release does not free space for a write in the same cycle.
- Status outputs (wr_ready, full, empty, counts) are combinational from registered pointers and valid in the cycle after any update.
- Invariant: rel_ptr <= rd_ptr <= wr_ptr, modulo ordering. The bench checks it every cycle.

Decomposition:
- Shared package tcp_buf_pkg holds:
  - default DATA_W / ADDR_W constants;
  - a function ptr_diff(a, b) for CNT_W subtraction;
  - a function min_cnt.
- One sub-module, sdp_ram: simple dual-port RAM with 1 write port and 1 registered read port, parameters DATA_W and ADDR_W, no reset on the array. The top-level holds pointer, clamp and flag logic only.

Test Plan:
- Reset, then write 0xA0..0xA2, then read 3 -> data_out 0xA0, 0xA1, 0xA2 on consecutive cycles after each rd_en, with rd_valid high; unread_count 3->0; used_count stays 3.
- ADDR_W=3: write 8 words, then a 9th -> full = 1, wr_ready = 0, wr_drop pulses once, the 9th word is not stored; used_count = 8.
- Wrap-around:
  - Read 8 and release 8 -> empty = 1.
  - Write 0xB0..0xB4 -> reads return 0xB0..0xB4.
  - wr_ptr = 13 (wrap bit set); counts are correct.
- Retransmit:
  - Write 4 words, read 4, release 1, then rd_rewind -> unread_count = 3.
  - Next reads return words 1..3.
  - rd_en asserted together with rd_rewind produces rd_valid = 0.
- Release clamp: 5 written, 2 read, release_count = 4 -> rel_ptr advances 2, release_err pulses, used_count = 3.
- Reset asserted mid-stream with wr_en, rd_en and release_en all high -> every pointer returns to 0, rd_valid = 0, empty = 1 on the next cycle.
